svm_coef_loader: RTL and testbench
==================================

Name: svm_coef_loader

Overview:
Host-side writer for the SVM coefficient RAM port (addr_a / write_en / i_data) and the bias port (bias / b_load) of the SVM detector.
- Accepts a serial stream of FEA_W-bit coefficients over a valid/ready handshake.
- Packs N_COEF coefficients into one RAM_DW-bit row and writes each row to consecutive addresses.
- After the last row it loads the bias and reports completion.
- Sits between the configuration bus/UART bridge and the SVM detector.

Parameters:
FEA_I, 4, integer bits of a coefficient
FEA_F, 8, fractional bits of a coefficient
FEA_W, FEA_I+FEA_F (localparam), coefficient width (COEF_W)
N_COEF, 105, coefficients per RAM row (15x7)
RAM_DW, FEA_W*N_COEF (localparam), RAM row width
N_ROWS, 36, rows to write
ADDR_W, 6, RAM address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  begin a load sequence; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE
s_valid  in  1  stream word valid
s_data  in  FEA_W  coefficient or bias word, two's complement Q(FEA_I.FEA_F)
s_ready  out  1  loader can accept s_data
addr_a  out  ADDR_W  RAM write address
write_en  out  1  one-cycle RAM write strobe
wr_data  out  RAM_DW  packed row; coef k at bits [FEA_W*k +: FEA_W]
bias  out  FEA_W  bias value
b_load  out  1  one-cycle bias load strobe
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; s_ready, write_en, b_load, busy, done = 0; addr_a, wr_data, bias, coef counter, row counter = 0.
- A word is accepted on any cycle with s_valid & s_ready. No combinational path from s_valid to s_ready.
- States:
  - IDLE: s_ready=0, busy=0. start=1 -> LOAD; row=0, k=0.
  - LOAD: s_ready=1, busy=1.
    - Each accepted word goes into the shift register: word enters at the MSB field and prior contents shift right by FEA_W. After N_COEF accepts, the first word sits at field 0 and the last at field N_COEF-1.
    - k increments per accept. The accept with k=N_COEF-1 -> WRITE, k=0.
  - WRITE: s_ready=0; write_en=1 for exactly this cycle, addr_a=row, wr_data=packed row.
    - Next: row=N_ROWS-1 -> BIAS, else row++ and LOAD.
    - Write latency: write_en is asserted the cycle after the final coefficient of the row is accepted.
  - BIAS: s_ready=1. The accepted word is registered to bias, with b_load=1 on the following cycle (state FIN).
  - FIN: b_load=1, done=1 for one cycle, busy=1 -> IDLE.
- bias holds its value until the next BIAS accept. addr_a holds its last value between writes. wr_data is don't-care when write_en=0 but must be stable during the write cycle.
- Gaps in s_valid stall the sequence indefinitely; no timeout.
- Words presented while s_ready=0 (IDLE, WRITE, FIN) are neither consumed nor dropped.
- start while busy: ignored.
- abort=1 in any state: next state IDLE, counters cleared, no write_en/b_load/done that cycle. Rows already written remain in RAM.
  - abort has priority over start and over an accept in the same cycle.
- Reset mid-operation behaves like abort, plus all registers are cleared.
- Total beats per sequence: N_ROWS*N_COEF + 1 = 3781.

Decomposition:
- Shared package/header: FEA_I, FEA_F, FEA_W, N_COEF, RAM_DW, ADDR_W, N_ROWS, plus FSM state encodings (IDLE, LOAD, WRITE, BIAS, FIN). The SVM detector and this loader must agree on these values.
- One natural sub-module: coef_packer. It holds the shift register and k counter, exposes row_full, and has a clear input.
- FSM and row counter stay in the top.

Test Plan:
1. Full load: start, then 3780 back-to-back words with value (row*105+k) mod 4096, then bias 12'h080 -> 36 write_en pulses at addr 0..35; row r field k = (r*105+k) mod 4096; bias=12'h080 with one b_load; done pulses exactly once; busy falls the cycle after done.
2. Throttled stream: s_valid toggles randomly at ~30% duty -> identical RAM image to scenario 1; write_en is never asserted while s_ready=1.
3. Boundary: row 0 with field 0=12'hFFF and field 104=12'h801 -> wr_data[11:0]=12'hFFF, wr_data[1259:1248]=12'h801; write_en exactly one cycle after the 105th accept.
4. start asserted again mid-row 10 -> ignored; sequence completes unchanged with 36 writes.
5. abort after row 5 written plus 50 words of row 6 -> IDLE next cycle; no further write_en; a fresh start rewrites from addr 0.
6. rst=0 for one cycle during BIAS -> all outputs 0 next cycle, state IDLE, no b_load or done pulse.

Source files
------------

// File: rtl/svm_coef_loader_pkg.sv
// Shared constants and FSM encoding for the SVM coefficient loader.
// The SVM detector must be built against the same row geometry.
package svm_coef_loader_pkg;
    localparam int FEA_I  = 4;
    localparam int FEA_F  = 8;
    localparam int FEA_W  = FEA_I + FEA_F;
    localparam int N_COEF = 105;
    localparam int RAM_DW = FEA_W * N_COEF;
    localparam int N_ROWS = 36;
    localparam int ADDR_W = 6;
    localparam int K_W    = $clog2(N_COEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_BIAS,
        ST_FIN
    } state_e;
endpackage

// File: rtl/svm_coef_loader_coef_packer.sv
// Shift-in packer: N_COEF serial coefficients become one RAM row, first word at field 0.
module coef_packer
    import svm_coef_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [FEA_W-1:0]  din_i,
    output logic [RAM_DW-1:0] row_o,
    output logic              row_full_o
);
    logic [RAM_DW-1:0] sr_q, sr_d;
    logic [K_W-1:0]    k_q, k_d;

    // Asserted on the push that completes the row.
    assign row_full_o = push_i && !clear_i && (k_q == K_W'(N_COEF - 1));
    assign row_o      = sr_q;

    always_comb begin
        sr_d = sr_q;
        k_d  = k_q;
        if (clear_i) begin
            k_d = '0;
        end else if (push_i) begin
            sr_d = {din_i, sr_q[RAM_DW-1:FEA_W]};
            k_d  = row_full_o ? '0 : k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= '0;
            k_q  <= '0;
        end else begin
            sr_q <= sr_d;
            k_q  <= k_d;
        end
    end
endmodule

// File: rtl/svm_coef_loader.sv
// Streams N_ROWS packed coefficient rows into the SVM RAM, then loads the bias.
// s_ready depends only on state and abort, never on s_valid.
module svm_coef_loader
    import svm_coef_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [FEA_W-1:0]  s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic              write_en,
    output logic [RAM_DW-1:0] wr_data,
    output logic [FEA_W-1:0]  bias,
    output logic              b_load,
    output logic              busy,
    output logic              done
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FEA_W-1:0]  bias_q, bias_d;
    logic              accept, pk_push, pk_clear, row_full;

    // abort outranks any accept in the same cycle, so it also drops s_ready.
    assign s_ready  = ((state_q == ST_LOAD) || (state_q == ST_BIAS)) && !abort;
    assign accept   = s_valid && s_ready;
    assign pk_push  = accept && (state_q == ST_LOAD);
    assign pk_clear = abort || (state_q == ST_IDLE);
    assign addr_a   = addr_q;
    assign bias     = bias_q;

    coef_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pk_clear),
        .push_i     (pk_push),
        .din_i      (s_data),
        .row_o      (wr_data),
        .row_full_o (row_full)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        addr_d   = addr_q;
        bias_d   = bias_q;
        write_en = 1'b0;
        b_load   = 1'b0;
        done     = 1'b0;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                end
            end
            ST_LOAD: begin
                if (row_full) begin
                    state_d = ST_WRITE;
                    addr_d  = row_q;
                end
            end
            ST_WRITE: begin
                write_en = 1'b1;
                if (row_q == ADDR_W'(N_ROWS - 1)) begin
                    state_d = ST_BIAS;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_BIAS: begin
                if (accept) begin
                    bias_d  = s_data;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                b_load  = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            row_d    = '0;
            write_en = 1'b0;
            b_load   = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            addr_q  <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            bias_q  <= bias_d;
        end
    end
endmodule

// File: tb/tb_svm_coef_loader.sv
// Randomized bench: RAM image and bias predicted from the word stream itself.
module tb_svm_coef_loader;
    import svm_coef_loader_pkg::*;

    localparam int NW = N_ROWS * N_COEF;

    logic              clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [FEA_W-1:0]  s_data = '0;
    logic              s_ready, write_en, b_load, busy, done;
    logic [ADDR_W-1:0] addr_a;
    logic [RAM_DW-1:0] wr_data;
    logic [FEA_W-1:0]  bias;

    always #5 clk = ~clk;

    svm_coef_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_a(addr_a), .write_en(write_en), .wr_data(wr_data),
        .bias(bias), .b_load(b_load), .busy(busy), .done(done)
    );

    int n_chk = 0, n_fail = 0;
    bit hung = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: records every RAM write and strobe seen on the outputs.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [RAM_DW-1:0] data;
        int                lat;
    } wr_t;

    wr_t              wq[$];
    int               cyc = 0, last_acc = -100, acc_cnt = 0, bl_cnt = 0, dn_cnt = 0, viol = 0;
    logic [FEA_W-1:0] bias_seen = '0;
    logic             done_prev = 1'b0, busy_after_done = 1'b1, busy_at_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            last_acc = cyc;
            acc_cnt++;
        end
        if (write_en) begin
            wq.push_back('{addr_a, wr_data, cyc - last_acc});
            if (s_ready) viol++;
        end
        if (b_load) begin
            bl_cnt++;
            bias_seen = bias;
        end
        if (done) begin
            dn_cnt++;
            busy_at_done = busy;
        end
        if (done_prev) busy_after_done = busy;
        done_prev = done;
    end

    logic [FEA_W-1:0] words [NW+1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [FEA_W-1:0] w, input int duty);
        int g;
        if (hung) return;
        while ($urandom_range(99) >= duty) begin
            s_valid = 1'b0;
            s_data  = FEA_W'($urandom);
            tick();
        end
        s_valid = 1'b1;
        s_data  = w;
        g = 0;
        @(negedge clk);
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            chk("ready_timeout", 32'(g), 32'd0);
            hung = 1'b1;
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic run_load(input int duty, input int start_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (i == start_at) start = 1'b1;
            push_word(words[i], duty);
            start = 1'b0;
        end
        push_word(words[NW], duty);
        repeat (3) tick();
    endtask

    task automatic check_run(input string tag, input int wbase, input int bl0, input int dn0, input int v0);
        chk({tag, "_nwrites"}, 32'(wq.size() - wbase), 32'(N_ROWS));
        for (int r = 0; r < N_ROWS; r++) begin
            if (wbase + r < wq.size()) begin
                chk($sformatf("%s_addr%0d", tag, r), 32'(wq[wbase+r].addr), 32'(r));
                chk($sformatf("%s_lat%0d", tag, r), 32'(wq[wbase+r].lat), 32'd1);
                for (int k = 0; k < N_COEF; k++)
                    chk($sformatf("%s_r%0d_f%0d", tag, r, k),
                        32'(wq[wbase+r].data[FEA_W*k +: FEA_W]), 32'(words[r*N_COEF+k]));
            end
        end
        chk({tag, "_bload_cnt"}, 32'(bl_cnt - bl0), 32'd1);
        chk({tag, "_bias"}, 32'(bias_seen), 32'(words[NW]));
        chk({tag, "_done_cnt"}, 32'(dn_cnt - dn0), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd1);
        chk({tag, "_busy_after_done"}, 32'(busy_after_done), 32'd0);
        chk({tag, "_we_while_ready"}, 32'(viol - v0), 32'd0);
    endtask

    task automatic fill_counting();
        for (int i = 0; i < NW; i++) words[i] = FEA_W'(i % 4096);
        words[NW] = 12'h080;
    endtask

    task automatic fill_random();
        for (int i = 0; i <= NW; i++) words[i] = FEA_W'($urandom);
    endtask

    initial begin
        int wb, b0, d0, v0, a0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_b_load", 32'(b_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_bias", 32'(bias), 32'd0);
        chk("rst_wr_data_zero", 32'(wr_data == '0), 32'd1);
        tick();
        rst = 1'b1;
        tick();

        // 1: full back-to-back load
        fill_counting();
        wb = wq.size(); b0 = bl_cnt; d0 = dn_cnt; v0 = viol;
        run_load(100, -1);
        check_run("full", wb, b0, d0, v0);

        // 2: throttled stream, same image
        wb = wq.size(); b0 = bl_cnt; d0 = dn_cnt; v0 = viol;
        run_load(30, -1);
        check_run("throttle", wb, b0, d0, v0);

        // 3: boundary field values in row 0
        fill_random();
        words[0]   = 12'hFFF;
        words[104] = 12'h801;
        wb = wq.size(); b0 = bl_cnt; d0 = dn_cnt; v0 = viol;
        run_load(70, -1);
        check_run("boundary", wb, b0, d0, v0);
        if (wb < wq.size()) begin
            chk("bnd_field0", 32'(wq[wb].data[11:0]), 32'h0FFF);
            chk("bnd_field104", 32'(wq[wb].data[1259:1248]), 32'h0801);
        end

        // 4: start re-asserted mid-row 10
        fill_counting();
        wb = wq.size(); b0 = bl_cnt; d0 = dn_cnt; v0 = viol;
        run_load(100, 10*N_COEF + 50);
        check_run("midstart", wb, b0, d0, v0);

        // 5: abort inside row 6, then a fresh load
        fill_random();
        wb = wq.size(); a0 = acc_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6*N_COEF + 50; i++) push_word(words[i], 100);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 12'h5A5;
        @(negedge clk);
        chk("abort_ready", 32'(s_ready), 32'd0);
        chk("abort_we", 32'(write_en), 32'd0);
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_idle_ready", 32'(s_ready), 32'd0);
        repeat (10) tick();
        chk("abort_nwrites", 32'(wq.size() - wb), 32'd6);
        chk("abort_accepts", 32'(acc_cnt - a0), 32'(6*N_COEF + 50));
        fill_random();
        wb = wq.size(); b0 = bl_cnt; d0 = dn_cnt; v0 = viol;
        run_load(100, -1);
        check_run("after_abort", wb, b0, d0, v0);

        // 6: reset pulse while waiting for the bias word
        fill_counting();
        wb = wq.size(); b0 = bl_cnt; d0 = dn_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NW; i++) push_word(words[i], 100);
        tick();
        chk("bias_state_ready", 32'(s_ready), 32'd1);
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 12'h3C3;
        tick();
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(s_ready), 32'd0);
        chk("rstmid_addr", 32'(addr_a), 32'd0);
        chk("rstmid_bias", 32'(bias), 32'd0);
        chk("rstmid_wr_data_zero", 32'(wr_data == '0), 32'd1);
        chk("rstmid_we", 32'(write_en), 32'd0);
        repeat (5) tick();
        chk("rstmid_nwrites", 32'(wq.size() - wb), 32'(N_ROWS));
        chk("rstmid_no_bload", 32'(bl_cnt - b0), 32'd0);
        chk("rstmid_no_done", 32'(dn_cnt - d0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
